multiport_reg_file: RTL and testbench
=====================================

# multiport_reg_file

Parametrised general-purpose register file for the CPU datapath: one write port, NUM_RD independent read ports, and registered read data on the rising edge. Register 0 is optionally hardwired to zero. Same-cycle write-to-read bypass is optional. A hardware clear sequencer zeroes the whole array after reset, or on request, and holds `ready` low while it runs. Sits between decode (read addresses) and writeback (write port).

## Interface
- DATA_W, 32: register width in bits
- ADDR_W, 5: address width; DEPTH = 2**ADDR_W entries
- NUM_RD, 2: number of read ports (≥1)
- ZERO_REG, 1: 1 = entry 0 reads 0 and ignores writes
- BYPASS, 1: 1 = same-cycle write data is forwarded to matching reads

Ports:
- Clk  in  1  clock; all logic on rising edge
- Rst_n  in  1  reset; synchronous, active-low
- wr_en  in  1  write request
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  registered read data; port k uses bits [k*DATA_W +: DATA_W]
- clr  in  1  request to re-zero the array (single-cycle pulse, ignored while clearing)
- ready  out  1  high when the array is initialised and writes are accepted

## Operation
- FSM states: CLEAR, RUN.
- CLEAR:
  - A pointer clr_ptr steps 0..DEPTH-1, writing 0 to one entry per cycle.
  - On the cycle clr_ptr == DEPTH-1 is written, the FSM moves to RUN.
  - wr_en is ignored; all rd_data samples are 0.
- RUN:
  - An accepted write (wr_en && ready) commits wr_data to entry wr_addr at the edge.
  - When ZERO_REG=1, a write with wr_addr == 0 is discarded.
- clr in RUN: state goes to CLEAR and clr_ptr goes to 0. Any write in the same cycle is dropped, because clr wins.
- Read, per port k, each edge. rd_data[k] gets:
  - 0, if state is CLEAR, or if ZERO_REG and rd_addr[k] == 0;
  - else wr_data, if BYPASS and an accepted write has wr_addr == rd_addr[k];
  - else the stored entry.
- Ports are fully independent. Any number of ports may read the same address.
- Widths: address compares are on the full ADDR_W. No arithmetic on data.

## Timing
- Reset (Rst_n low at an edge):
  - rd_data = all 0, ready = 0, state = CLEAR, clr_ptr = 0.
  - Array contents are undefined until the clear completes.
- After Rst_n is released, CLEAR takes exactly DEPTH cycles. ready rises at the edge ending the last clear write. For DEPTH=32, ready is high from the 32nd edge after release.
- Reset asserted mid-CLEAR or mid-RUN: the sequence restarts from clr_ptr = 0. No partial state is retained.
- Read latency: 1 cycle from rd_addr to rd_data. No combinational path from address to output.
- Write-to-read:
  - BYPASS=1: a read at the same edge as the write returns the new data.
  - BYPASS=0: that read returns the old data, and the new data is visible one edge later.
- clr accepted at edge N: ready is low after edge N and high again after edge N+DEPTH.
- ready is registered and only deasserts due to clr or reset.

## Structure
- Shared package reg_file_pkg:
  - default DATA_W and ADDR_W localparams;
  - state enum type (CLEAR, RUN).
- Sub-module rd_port:
  - one read port's zero-check, bypass mux and output register;
  - instantiated NUM_RD times via generate.
- Top level holds the storage array, the write/clear mux, clr_ptr and the FSM.

## Test plan
- Reset release, defaults: ready is 0 for 32 cycles, then 1. Reading every address returns 0x00000000.
- Write 0xDEADBEEF to r5, then read r5 on port 0 and port 1 the next cycle: both return 0xDEADBEEF after 1-cycle latency.
- Write 0x12345678 to r0, then read r0: returns 0. Repeat with ZERO_REG=0: returns 0x12345678.
- Same-edge write of 0xA5A5A5A5 to r7 with rd_addr0 = 7:
  - BYPASS=1: rd_data0 = 0xA5A5A5A5.
  - BYPASS=0: rd_data0 = the old value, and 0xA5A5A5A5 the following cycle.
- In RUN, pulse clr together with a write of 0x1 to r3: ready drops for 32 cycles, the write is dropped, and r3 then reads 0.
- Assert Rst_n low for 1 cycle at clear step 10: ready stays low for a further full 32 cycles after release. Writes issued while ready = 0 have no effect.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared defaults and state type for the multi-port register file.
package reg_file_pkg;

  localparam int unsigned DefDataW = 32;
  localparam int unsigned DefAddrW = 5;

  typedef enum logic {
    StClear = 1'b0,
    StRun   = 1'b1
  } rf_state_e;

endpackage

// File: rtl/rd_port.sv
// One read port: zero-register check, write bypass and registered read data.
module rd_port #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clearing_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic [DATA_W-1:0] entry_i,
  input  logic              wr_acc_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] rd_data_d, rd_data_q;

  // Zero check has priority so a bypassed write to r0 never leaks out.
  always_comb begin
    rd_data_d = entry_i;
    if (clearing_i) begin
      rd_data_d = '0;
    end else if (ZERO_REG && (rd_addr_i == '0)) begin
      rd_data_d = '0;
    end else if (BYPASS && wr_acc_i && (wr_addr_i == rd_addr_i)) begin
      rd_data_d = wr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/multiport_reg_file.sv
// Register file with one write port, NUM_RD registered read ports and a
// sequential clear engine that zeroes the array after reset or on clr.
module multiport_reg_file
  import reg_file_pkg::*;
#(
  parameter int unsigned DATA_W   = DefDataW,
  parameter int unsigned ADDR_W   = DefAddrW,
  parameter int unsigned NUM_RD   = 2,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     clr,
  output logic                     ready
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  rf_state_e         state_q;
  logic [ADDR_W-1:0] clr_ptr_q;
  logic              ready_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              clearing;
  logic              wr_acc;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  assign clearing = (state_q == StClear);
  // clr in the same cycle wins over a write.
  assign wr_acc   = wr_en && ready_q && !clr;

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    if (clearing) begin
      mem_we    = Rst_n;
      mem_waddr = clr_ptr_q;
      mem_wdata = '0;
    end else if (wr_acc && !(ZERO_REG && (wr_addr == '0))) begin
      mem_we = Rst_n;
    end
  end

  always_ff @(posedge Clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q   <= StClear;
      clr_ptr_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StClear: begin
          clr_ptr_q <= clr_ptr_q + ADDR_W'(1);
          if (&clr_ptr_q) begin
            state_q <= StRun;
            ready_q <= 1'b1;
          end
        end
        StRun: begin
          if (clr) begin
            state_q   <= StClear;
            clr_ptr_q <= '0;
            ready_q   <= 1'b0;
          end
        end
      endcase
    end
  end

  assign ready = ready_q;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    assign addr = rd_addr[k*ADDR_W +: ADDR_W];

    rd_port #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .ZERO_REG(ZERO_REG),
      .BYPASS  (BYPASS)
    ) u_rd_port (
      .clk_i     (Clk),
      .rst_ni    (Rst_n),
      .clearing_i(clearing),
      .rd_addr_i (addr),
      .entry_i   (mem_q[addr]),
      .wr_acc_i  (wr_acc),
      .wr_addr_i (wr_addr),
      .wr_data_i (wr_data),
      .rd_data_o (rd_data[k*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_multiport_reg_file.sv
// Randomised and directed bench for multiport_reg_file, run on two configurations.
module tb_multiport_reg_file;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int DEPTH = 32;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic             Rst_n, wr_en, clr;
  logic [AW-1:0]    wr_addr;
  logic [DW-1:0]    wr_data;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data0, rd_data1;
  logic             ready0, ready1;

  multiport_reg_file #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1'b1), .BYPASS(1'b1)
  ) dut (
    .Clk(Clk), .Rst_n(Rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data0), .clr(clr), .ready(ready0)
  );

  multiport_reg_file #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1'b0), .BYPASS(1'b0)
  ) dut_alt (
    .Clk(Clk), .Rst_n(Rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data1), .clr(clr), .ready(ready1)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: config 0 = zero reg + bypass, config 1 = neither.
  bit            m_zr [2] = '{1'b1, 1'b0};
  bit            m_bp [2] = '{1'b1, 1'b0};
  logic [DW-1:0] m_mem [2][DEPTH];
  logic [DW-1:0] m_rd  [2][NR];
  bit            m_ready;
  bit            m_clear;
  int            m_left;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic [AW-1:0] a;
    if (!Rst_n) begin
      m_clear = 1'b1;
      m_left  = DEPTH;
      m_ready = 1'b0;
      for (int c = 0; c < 2; c++) for (int k = 0; k < NR; k++) m_rd[c][k] = '0;
    end else if (m_clear) begin
      for (int c = 0; c < 2; c++) for (int k = 0; k < NR; k++) m_rd[c][k] = '0;
      m_left--;
      if (m_left == 0) begin
        m_clear = 1'b0;
        m_ready = 1'b1;
        for (int c = 0; c < 2; c++) for (int i = 0; i < DEPTH; i++) m_mem[c][i] = '0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        for (int k = 0; k < NR; k++) begin
          a = rd_addr[k*AW +: AW];
          if (m_zr[c] && a == 0) m_rd[c][k] = '0;
          else if (m_bp[c] && wr_en && !clr && wr_addr == a) m_rd[c][k] = wr_data;
          else m_rd[c][k] = m_mem[c][a];
        end
      end
      if (clr) begin
        m_clear = 1'b1;
        m_left  = DEPTH;
        m_ready = 1'b0;
      end else if (wr_en) begin
        for (int c = 0; c < 2; c++)
          if (!(m_zr[c] && wr_addr == 0)) m_mem[c][wr_addr] = wr_data;
      end
    end
  endtask

  // One clock: advance the model at the edge, then compare every output.
  task automatic cycle();
    @(posedge Clk);
    model_edge();
    #1;
    chk("ready", {31'b0, ready0}, {31'b0, m_ready});
    chk("ready_alt", {31'b0, ready1}, {31'b0, m_ready});
    for (int k = 0; k < NR; k++) begin
      chk($sformatf("rd_data[%0d]", k), rd_data0[k*DW +: DW], m_rd[0][k]);
      chk($sformatf("rd_data_alt[%0d]", k), rd_data1[k*DW +: DW], m_rd[1][k]);
    end
  endtask

  task automatic idle();
    Rst_n = 1'b1; wr_en = 1'b0; clr = 1'b0;
  endtask

  task automatic set_rd(input int a0, input int a1);
    rd_addr = {AW'(a1), AW'(a0)};
  endtask

  initial begin
    Rst_n = 1'b0; wr_en = 1'b0; clr = 1'b0;
    wr_addr = '0; wr_data = '0; rd_addr = '0;
    cycle();
    cycle();
    chk("reset_ready", {31'b0, ready0}, 32'd0);
    chk("reset_rd0", rd_data0[DW-1:0], 32'd0);

    // Post-reset clear with stray writes that must be ignored.
    idle();
    for (int i = 0; i < DEPTH; i++) begin
      wr_en = 1'b1; wr_addr = AW'(i); wr_data = $urandom;
      set_rd($urandom_range(0, 31), $urandom_range(0, 31));
      cycle();
      chk("init_ready", {31'b0, ready0}, (i == DEPTH - 1) ? 32'd1 : 32'd0);
    end
    wr_en = 1'b0;
    for (int j = 0; j < DEPTH / 2; j++) begin
      set_rd(2 * j, 2 * j + 1);
      cycle();
      chk("init_zero_p0", rd_data1[DW-1:0], 32'd0);
      chk("init_zero_p1", rd_data1[2*DW-1:DW], 32'd0);
    end

    // Write r5, read on both ports.
    wr_en = 1'b1; wr_addr = 5; wr_data = 32'hDEADBEEF; set_rd(1, 2);
    cycle();
    wr_en = 1'b0; set_rd(5, 5);
    cycle();
    chk("r5_p0", rd_data0[DW-1:0], 32'hDEADBEEF);
    chk("r5_p1", rd_data0[2*DW-1:DW], 32'hDEADBEEF);

    // Write r0: zero register discards it, the other config stores it.
    wr_en = 1'b1; wr_addr = 0; wr_data = 32'h12345678; set_rd(1, 1);
    cycle();
    wr_en = 1'b0; set_rd(0, 0);
    cycle();
    chk("r0_zero", rd_data0[DW-1:0], 32'd0);
    chk("r0_nozero", rd_data1[DW-1:0], 32'h12345678);

    // Same-edge write/read of r7.
    wr_en = 1'b1; wr_addr = 7; wr_data = 32'hA5A5A5A5; set_rd(7, 3);
    cycle();
    chk("r7_bypass", rd_data0[DW-1:0], 32'hA5A5A5A5);
    chk("r7_nobypass_old", rd_data1[DW-1:0], 32'd0);
    wr_en = 1'b0;
    cycle();
    chk("r7_nobypass_new", rd_data1[DW-1:0], 32'hA5A5A5A5);

    // clr together with a write to r3: write dropped, full re-clear.
    clr = 1'b1; wr_en = 1'b1; wr_addr = 3; wr_data = 32'h1; set_rd(3, 5);
    cycle();
    chk("clr_ready_drop", {31'b0, ready0}, 32'd0);
    clr = 1'b0; wr_en = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      cycle();
      chk("clr_ready", {31'b0, ready0}, (i == DEPTH - 1) ? 32'd1 : 32'd0);
    end
    set_rd(3, 5);
    cycle();
    chk("clr_r3", rd_data0[DW-1:0], 32'd0);
    chk("clr_r5", rd_data1[2*DW-1:DW], 32'd0);

    // Reset at clear step 10 restarts the full sequence.
    clr = 1'b1;
    cycle();
    clr = 1'b0; wr_en = 1'b1; wr_addr = 9; wr_data = 32'h0000FFFF;
    for (int i = 0; i < 10; i++) cycle();
    Rst_n = 1'b0;
    cycle();
    chk("midclr_rst_ready", {31'b0, ready1}, 32'd0);
    Rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      cycle();
      chk("midclr_ready", {31'b0, ready1}, (i == DEPTH - 1) ? 32'd1 : 32'd0);
    end
    wr_en = 1'b0; set_rd(9, 9);
    cycle();
    chk("midclr_r9", rd_data0[DW-1:0], 32'd0);
    chk("midclr_r9_alt", rd_data1[DW-1:0], 32'd0);

    // Random traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      Rst_n   = ($urandom_range(0, 599) != 0);
      clr     = ($urandom_range(0, 249) == 0);
      wr_en   = ($urandom_range(0, 3) != 0);
      wr_addr = AW'($urandom_range(0, 31));
      wr_data = $urandom;
      for (int k = 0; k < NR; k++)
        rd_addr[k*AW +: AW] = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom_range(0, 31));
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
